// File: rtl/axil4_master_rd_mon.sv
// AXI4-Lite read-channel pass-through monitor: tracks outstanding reads in order and
// emits 64-bit monitor packets for completions, errors, orphans and timeouts.
module axil4_master_rd_mon #(
    parameter int              AXIL_ADDR_WIDTH = 32,
    parameter int              AXIL_DATA_WIDTH = 32,
    parameter int              MAX_OUTSTANDING = 4,
    parameter logic [3:0]      UNIT_ID         = 4'd2,
    parameter logic [7:0]      AGENT_ID        = 8'd21
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXIL_ADDR_WIDTH-1:0] fub_araddr,
    input  logic [2:0]                 fub_arprot,
    input  logic                       fub_arvalid,
    output logic                       fub_arready,
    output logic [AXIL_DATA_WIDTH-1:0] fub_rdata,
    output logic [1:0]                 fub_rresp,
    output logic                       fub_rvalid,
    input  logic                       fub_rready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready,
    input  logic                       cfg_timeout_enable,
    input  logic [15:0]                cfg_timeout_cycles,
    input  logic                       cfg_compl_enable,
    output logic                       monbus_valid,
    input  logic                       monbus_ready,
    output logic [63:0]                monbus_packet,
    output logic [7:0]                 active_transactions,
    output logic [15:0]                error_count,
    output logic [31:0]                transaction_count,
    output logic [7:0]                 dropped_packets,
    output logic                       busy
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    function automatic logic [13:0] sat14(input logic [15:0] v);
        if (v > 16'h3FFF) begin
            return 14'h3FFF;
        end else begin
            return v[13:0];
        end
    endfunction

    logic [15:0]          ts_q, ts_d;
    logic [31:0]          addr_mem_q [MAX_OUTSTANDING];
    logic [31:0]          addr_mem_d [MAX_OUTSTANDING];
    logic [15:0]          tsm_q [MAX_OUTSTANDING];
    logic [15:0]          tsm_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] to_flag_q, to_flag_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 mon_valid_q, mon_valid_d;
    logic [63:0]          mon_pkt_q, mon_pkt_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [31:0]          txn_cnt_q, txn_cnt_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic                 full_s, push_s, r_hs_s, pop_s, orphan_s, pop_err_s, timeout_s;
    logic                 event_s;
    logic [31:0]          addr32_s;
    logic [15:0]          head_age_s;
    logic [3:0]           ev_type_s;
    logic [1:0]           ev_resp_s;
    logic [13:0]          ev_lat_s;
    logic [31:0]          ev_addr_s;

    if (AXIL_ADDR_WIDTH >= 32) begin : g_addr_trunc
        assign addr32_s = fub_araddr[31:0];
    end else begin : g_addr_ext
        assign addr32_s = {{(32-AXIL_ADDR_WIDTH){1'b0}}, fub_araddr};
    end

    assign full_s         = (count_q == FULL_CNT);
    assign m_axil_araddr  = fub_araddr;
    assign m_axil_arprot  = fub_arprot;
    assign m_axil_arvalid = fub_arvalid & ~full_s;
    assign fub_arready    = m_axil_arready & ~full_s;
    assign fub_rdata      = m_axil_rdata;
    assign fub_rresp      = m_axil_rresp;
    assign fub_rvalid     = m_axil_rvalid;
    assign m_axil_rready  = fub_rready;

    assign push_s     = fub_arvalid & m_axil_arready & ~full_s;
    assign r_hs_s     = m_axil_rvalid & fub_rready;
    assign pop_s      = r_hs_s & (count_q != '0);
    assign orphan_s   = r_hs_s & (count_q == '0);
    assign pop_err_s  = pop_s & m_axil_rresp[1];
    assign head_age_s = ts_q - tsm_q[rd_ptr_q];
    // Any R handshake this cycle pre-empts the timeout; it is re-checked against the next head.
    assign timeout_s  = (count_q != '0) & cfg_timeout_enable & (cfg_timeout_cycles != 16'd0)
                      & (head_age_s >= cfg_timeout_cycles) & ~to_flag_q[rd_ptr_q] & ~r_hs_s;

    // Event selection and packet field formation
    always_comb begin
        event_s   = 1'b0;
        ev_type_s = 4'h0;
        ev_resp_s = 2'b00;
        ev_lat_s  = 14'd0;
        ev_addr_s = 32'd0;
        if (orphan_s) begin
            event_s   = 1'b1;
            ev_type_s = 4'h3;
            ev_resp_s = m_axil_rresp;
        end else if (pop_err_s) begin
            event_s   = 1'b1;
            ev_type_s = 4'h0;
            ev_resp_s = m_axil_rresp;
            ev_lat_s  = sat14(head_age_s);
            ev_addr_s = addr_mem_q[rd_ptr_q];
        end else if (pop_s && cfg_compl_enable) begin
            event_s   = 1'b1;
            ev_type_s = 4'h2;
            ev_resp_s = m_axil_rresp;
            ev_lat_s  = sat14(head_age_s);
            ev_addr_s = addr_mem_q[rd_ptr_q];
        end else if (timeout_s) begin
            event_s   = 1'b1;
            ev_type_s = 4'h1;
            ev_lat_s  = sat14(head_age_s);
            ev_addr_s = addr_mem_q[rd_ptr_q];
        end else begin
            event_s   = 1'b0;
        end
    end

    // Next-state for tracking FIFO, counters and monitor output register
    always_comb begin
        ts_d        = ts_q + 16'd1;
        addr_mem_d  = addr_mem_q;
        tsm_d       = tsm_q;
        to_flag_d   = to_flag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mon_valid_d = mon_valid_q;
        mon_pkt_d   = mon_pkt_q;
        err_cnt_d   = err_cnt_q;
        txn_cnt_d   = txn_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (push_s) begin
            addr_mem_d[wr_ptr_q] = addr32_s;
            tsm_d[wr_ptr_q]      = ts_q;
            to_flag_d[wr_ptr_q]  = 1'b0;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            to_flag_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + PTR_W'(1);
            txn_cnt_d           = txn_cnt_q + 32'd1;
        end else if (timeout_s) begin
            to_flag_d[rd_ptr_q] = 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if ((orphan_s || pop_err_s) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        if (event_s && (!mon_valid_q || monbus_ready)) begin
            mon_valid_d = 1'b1;
            mon_pkt_d   = {ev_type_s, UNIT_ID, AGENT_ID, ev_resp_s, ev_lat_s, ev_addr_s};
        end else if (mon_valid_q && monbus_ready) begin
            mon_valid_d = 1'b0;
        end else begin
            mon_valid_d = mon_valid_q;
        end

        if (event_s && mon_valid_q && !monbus_ready && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_q        <= 16'd0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                addr_mem_q[i] <= 32'd0;
                tsm_q[i]      <= 16'd0;
            end
            to_flag_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mon_valid_q <= 1'b0;
            mon_pkt_q   <= 64'd0;
            err_cnt_q   <= 16'd0;
            txn_cnt_q   <= 32'd0;
            drop_cnt_q  <= 8'd0;
        end else begin
            ts_q        <= ts_d;
            addr_mem_q  <= addr_mem_d;
            tsm_q       <= tsm_d;
            to_flag_q   <= to_flag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mon_valid_q <= mon_valid_d;
            mon_pkt_q   <= mon_pkt_d;
            err_cnt_q   <= err_cnt_d;
            txn_cnt_q   <= txn_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign monbus_valid        = mon_valid_q;
    assign monbus_packet       = mon_pkt_q;
    assign active_transactions = 8'(count_q);
    assign error_count         = err_cnt_q;
    assign transaction_count   = txn_cnt_q;
    assign dropped_packets     = drop_cnt_q;
    assign busy                = (count_q != '0) | mon_valid_q;

endmodule
